// File: rtl/mbist_pkg.sv
// Shared encodings and constants for the MBIST data-background generator.
package mbist_pkg;

  typedef enum logic [2:0] {
    PAT_MSCAN   = 3'd0,
    PAT_CHECKER = 3'd1,
    PAT_MARCHC  = 3'd2,
    PAT_WALK1   = 3'd3,
    PAT_PRBS    = 3'd4
  } pat_e;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  localparam int MARCH_ELEMS = 6;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'(LFSR_TAPS_8);
      16:      return 32'(LFSR_TAPS_16);
      default: return LFSR_TAPS_32;
    endcase
  endfunction

endpackage

// File: rtl/mbist_pattern_gen_if.sv
// Controller-side bus of the MBIST pattern generator: generation/compare requests and status.
interface mbist_pattern_gen_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 8
);
  logic              START;
  logic              DATA_EN;
  logic [2:0]        PAT_SEL;
  logic [3:0]        ELEM;
  logic [ADDR_W-1:0] ADDR;
  logic              RD_VALID;
  logic [DATA_W-1:0] RD_DATA;
  logic [DATA_W-1:0] DATA_MBIST;
  logic [DATA_W-1:0] DATA_comp;
  logic              DATA_VALID;
  logic              PAT_ERR;
  logic              FAIL;
  logic [ADDR_W-1:0] FAIL_ADDR;
  logic [DATA_W-1:0] FAIL_MASK;
  logic [ERR_W-1:0]  ERR_CNT;

  modport master (
    output START, DATA_EN, PAT_SEL, ELEM, ADDR, RD_VALID, RD_DATA,
    input  DATA_MBIST, DATA_comp, DATA_VALID, PAT_ERR, FAIL, FAIL_ADDR, FAIL_MASK, ERR_CNT
  );

  modport slave (
    input  START, DATA_EN, PAT_SEL, ELEM, ADDR, RD_VALID, RD_DATA,
    output DATA_MBIST, DATA_comp, DATA_VALID, PAT_ERR, FAIL, FAIL_ADDR, FAIL_MASK, ERR_CNT
  );
endinterface

// File: rtl/mbist_lfsr.sv
// Galois PRBS register, shifting right; load forces the seed, load+en steps from the seed.
// Single-cycle update, no backpressure.
module mbist_lfsr
  import mbist_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] state
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic [DATA_W-1:0] state_d, state_q;

  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = en ? step(seed) : seed;
    end else if (en) begin
      state_d = step(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_VAL;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/mbist_pattern_gen.sv
// MBIST write/expected data generator with read comparator and sticky fail capture.
// Outputs register on the DATA_EN edge (1-cycle latency); no backpressure, every strobe is consumed.
module mbist_pattern_gen
  import mbist_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int ERR_W     = 8,
  parameter int LFSR_SEED = 1
) (
  input logic           CLK,
  input logic           nRESET,
  mbist_pattern_gen_if.slave bus
);

  localparam int                SH_W     = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] SEED_T   = DATA_W'(LFSR_SEED);
  localparam logic [DATA_W-1:0] SEED_EFF = (SEED_T == '0) ? DATA_W'(1) : SEED_T;
  localparam logic [DATA_W-1:0] CB       = {(DATA_W/2){2'b01}};
  localparam logic [3:0]        ELEM_MAX = 4'(MARCH_ELEMS - 1);

  logic [DATA_W-1:0] wdat_d, wdat_q;
  logic [DATA_W-1:0] comp_d, comp_q;
  logic              valid_d, valid_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              paterr_d, paterr_q;
  logic              fail_d, fail_q;
  logic [ADDR_W-1:0] faddr_d, faddr_q;
  logic [DATA_W-1:0] fmask_d, fmask_q;
  logic [ERR_W-1:0]  cnt_d, cnt_q;

  logic [DATA_W-1:0] lfsr_val;
  logic [DATA_W-1:0] prbs_val;
  logic [DATA_W-1:0] walk;
  logic [3:0]        elem_c;
  logic [DATA_W-1:0] gen_w, gen_c;
  logic              gen_rsv;
  logic              mismatch;

  mbist_lfsr #(
    .DATA_W  (DATA_W),
    .RST_VAL (SEED_EFF)
  ) u_lfsr (
    .clk   (CLK),
    .rst_n (nRESET),
    .load  (bus.START),
    .en    (bus.DATA_EN && (bus.PAT_SEL == PAT_PRBS)),
    .seed  (SEED_EFF),
    .state (lfsr_val)
  );

  // A START in the same cycle reseeds, so the strobed PRBS word is the seed itself.
  assign prbs_val = bus.START ? SEED_EFF : lfsr_val;
  assign walk     = DATA_W'(1) << bus.ADDR[SH_W-1:0];
  assign elem_c   = (bus.ELEM > ELEM_MAX) ? ELEM_MAX : bus.ELEM;

  always_comb begin
    gen_w   = '0;
    gen_c   = '0;
    gen_rsv = 1'b0;
    case (bus.PAT_SEL)
      PAT_MSCAN: begin
        gen_w = bus.ELEM[0] ? '1 : '0;
        gen_c = gen_w;
      end
      PAT_CHECKER: begin
        gen_w = (bus.ADDR[0] ^ bus.ELEM[0]) ? ~CB : CB;
        gen_c = gen_w;
      end
      PAT_MARCHC: begin
        gen_w = elem_c[0] ? '1 : '0;
        gen_c = (elem_c == 4'd0) ? '0 : ~gen_w;
      end
      PAT_WALK1: begin
        gen_w = bus.ELEM[0] ? ~walk : walk;
        gen_c = gen_w;
      end
      PAT_PRBS: begin
        gen_w = prbs_val;
        gen_c = prbs_val;
      end
      default: gen_rsv = 1'b1;
    endcase
  end

  assign mismatch = bus.RD_VALID && (bus.RD_DATA != comp_q);

  always_comb begin
    wdat_d   = wdat_q;
    comp_d   = comp_q;
    addr_d   = addr_q;
    paterr_d = paterr_q;
    fail_d   = fail_q;
    faddr_d  = faddr_q;
    fmask_d  = fmask_q;
    cnt_d    = cnt_q;
    valid_d  = bus.DATA_EN;

    // Compare always sees the pre-edge expected value and address.
    if (bus.START) begin
      paterr_d = 1'b0;
      fail_d   = 1'b0;
      faddr_d  = '0;
      fmask_d  = '0;
      cnt_d    = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + ERR_W'(1);
      if (!fail_q) begin
        faddr_d = addr_q;
        fmask_d = bus.RD_DATA ^ comp_q;
      end
    end

    if (bus.DATA_EN) begin
      wdat_d = gen_w;
      comp_d = gen_c;
      addr_d = bus.ADDR;
      if (gen_rsv) paterr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wdat_q   <= '0;
      comp_q   <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      paterr_q <= 1'b0;
      fail_q   <= 1'b0;
      faddr_q  <= '0;
      fmask_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wdat_q   <= wdat_d;
      comp_q   <= comp_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      paterr_q <= paterr_d;
      fail_q   <= fail_d;
      faddr_q  <= faddr_d;
      fmask_q  <= fmask_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.DATA_MBIST = wdat_q;
  assign bus.DATA_comp  = comp_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.PAT_ERR    = paterr_q;
  assign bus.FAIL       = fail_q;
  assign bus.FAIL_ADDR  = faddr_q;
  assign bus.FAIL_MASK  = fmask_q;
  assign bus.ERR_CNT    = cnt_q;

endmodule

// File: tb/tb_mbist_pattern_gen.sv
// Directed plus randomized bench for mbist_pattern_gen at DATA_W=8, checked against a rule-level model.
module tb_mbist_pattern_gen;

  localparam logic [7:0] SEED = 8'h01;

  logic clk = 1'b0;
  logic nreset;

  mbist_pattern_gen_if #(.DATA_W(8), .ADDR_W(8), .ERR_W(8)) bus();

  mbist_pattern_gen #(
    .DATA_W(8), .ADDR_W(8), .ERR_W(8), .LFSR_SEED(1)
  ) dut (
    .CLK    (clk),
    .nRESET (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] m_w, m_c, m_addr, m_faddr, m_fmask, m_cnt, m_lfsr;
  logic       m_valid, m_fail, m_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] prbs_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic ref_gen(input logic [2:0] p, input logic [3:0] e, input logic [7:0] a,
                         input logic [7:0] pv, output logic [7:0] w, output logic [7:0] c,
                         output logic rsv);
    int ec;
    rsv = 1'b0;
    w   = 8'h00;
    c   = 8'h00;
    case (p)
      3'd0: begin w = e[0] ? 8'hFF : 8'h00; c = w; end
      3'd1: begin w = (a[0] ^ e[0]) ? 8'hAA : 8'h55; c = w; end
      3'd2: begin
        ec = (int'(e) > 5) ? 5 : int'(e);
        w  = (ec % 2 == 1) ? 8'hFF : 8'h00;
        c  = (ec == 0) ? 8'h00 : ~w;
      end
      3'd3: begin w = 8'h01 << (a % 8); if (e[0]) w = ~w; c = w; end
      3'd4: begin w = pv; c = pv; end
      default: rsv = 1'b1;
    endcase
  endtask

  task automatic model_reset();
    m_w = 0; m_c = 0; m_addr = 0; m_faddr = 0; m_fmask = 0; m_cnt = 0;
    m_valid = 0; m_fail = 0; m_perr = 0; m_lfsr = SEED;
  endtask

  task automatic check_all();
    chk("DATA_MBIST", 32'(bus.DATA_MBIST), 32'(m_w));
    chk("DATA_comp",  32'(bus.DATA_comp),  32'(m_c));
    chk("DATA_VALID", 32'(bus.DATA_VALID), 32'(m_valid));
    chk("PAT_ERR",    32'(bus.PAT_ERR),    32'(m_perr));
    chk("FAIL",       32'(bus.FAIL),       32'(m_fail));
    chk("FAIL_ADDR",  32'(bus.FAIL_ADDR),  32'(m_faddr));
    chk("FAIL_MASK",  32'(bus.FAIL_MASK),  32'(m_fmask));
    chk("ERR_CNT",    32'(bus.ERR_CNT),    32'(m_cnt));
  endtask

  task automatic drive(input logic st, input logic en, input logic [2:0] p, input logic [3:0] e,
                       input logic [7:0] a, input logic rv, input logic [7:0] rd);
    bus.START = st; bus.DATA_EN = en; bus.PAT_SEL = p; bus.ELEM = e;
    bus.ADDR = a; bus.RD_VALID = rv; bus.RD_DATA = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 8'd0);
  endtask

  // Advance one clock with the inputs currently driven, updating the model first.
  task automatic cyc();
    logic [7:0] w, c, pv;
    logic       rsv;
    pv = bus.START ? SEED : m_lfsr;
    ref_gen(bus.PAT_SEL, bus.ELEM, bus.ADDR, pv, w, c, rsv);
    if (bus.START) begin
      m_perr = 0; m_fail = 0; m_faddr = 0; m_fmask = 0; m_cnt = 0; m_lfsr = SEED;
    end else if (bus.RD_VALID && bus.RD_DATA !== m_c) begin
      if (!m_fail) begin
        m_faddr = m_addr;
        m_fmask = bus.RD_DATA ^ m_c;
      end
      m_fail = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    if (bus.DATA_EN && bus.PAT_SEL == 3'd4) m_lfsr = prbs_next(pv);
    if (bus.DATA_EN) begin
      m_w = w; m_c = c; m_addr = bus.ADDR;
      if (rsv) m_perr = 1'b1;
    end
    m_valid = bus.DATA_EN;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic gen(input logic [2:0] p, input logic [3:0] e, input logic [7:0] a);
    drive(1'b0, 1'b1, p, e, a, 1'b0, 8'd0);
    cyc();
    idle();
  endtask

  task automatic read(input logic [7:0] rd);
    drive(1'b0, 1'b0, 3'd0, 4'd0, 8'd0, 1'b1, rd);
    cyc();
    idle();
  endtask

  initial begin
    idle();
    nreset = 1'b1;
    #2 nreset = 1'b0;
    model_reset();
    #1 check_all();

    // Reset held while DATA_EN toggles: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'(i % 2), 3'd0, 4'd1, 8'd0, 1'b0, 8'd0);
      @(posedge clk);
      #1 check_all();
    end
    idle();
    nreset = 1'b1;

    gen(3'd0, 4'd1, 8'd0);
    chk("mscan_w", 32'(bus.DATA_MBIST), 32'h FF);
    chk("mscan_c", 32'(bus.DATA_comp), 32'hFF);
    chk("mscan_vld", 32'(bus.DATA_VALID), 32'd1);
    cyc();
    chk("vld_pulse", 32'(bus.DATA_VALID), 32'd0);

    gen(3'd1, 4'd0, 8'd0); chk("cb_a0", 32'(bus.DATA_MBIST), 32'h55);
    gen(3'd1, 4'd0, 8'd1); chk("cb_a1", 32'(bus.DATA_MBIST), 32'hAA);
    gen(3'd1, 4'd0, 8'd2); chk("cb_a2", 32'(bus.DATA_MBIST), 32'h55);
    gen(3'd1, 4'd1, 8'd0); chk("cb_e1", 32'(bus.DATA_MBIST), 32'hAA);

    for (int e = 0; e < 6; e++) gen(3'd2, 4'(e), 8'd0);
    gen(3'd2, 4'd9, 8'd0);
    chk("marchc_e9_w", 32'(bus.DATA_MBIST), 32'hFF);
    chk("marchc_e9_c", 32'(bus.DATA_comp), 32'h00);
    gen(3'd2, 4'd2, 8'd0);
    chk("marchc_e2_c", 32'(bus.DATA_comp), 32'hFF);

    for (int a = 0; a < 10; a++) gen(3'd3, 4'(a % 2), 8'(a));

    gen(3'd4, 4'd0, 8'd0); chk("prbs0", 32'(bus.DATA_MBIST), 32'h01);
    gen(3'd4, 4'd0, 8'd0); chk("prbs1", 32'(bus.DATA_MBIST), 32'hB8);
    gen(3'd4, 4'd0, 8'd0); chk("prbs2", 32'(bus.DATA_MBIST), 32'h5C);
    drive(1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 8'd0); cyc(); idle();
    gen(3'd4, 4'd0, 8'd0); chk("prbs0_again", 32'(bus.DATA_MBIST), 32'h01);
    gen(3'd4, 4'd0, 8'd0); chk("prbs1_again", 32'(bus.DATA_MBIST), 32'hB8);
    gen(3'd4, 4'd0, 8'd0); chk("prbs2_again", 32'(bus.DATA_MBIST), 32'h5C);

    // First-fail capture, then a second fail only moves the counter.
    drive(1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 8'd0); cyc(); idle();
    gen(3'd1, 4'd0, 8'd3);
    read(8'hAB);
    chk("ff_fail", 32'(bus.FAIL), 32'd1);
    chk("ff_addr", 32'(bus.FAIL_ADDR), 32'd3);
    chk("ff_mask", 32'(bus.FAIL_MASK), 32'h01);
    chk("ff_cnt", 32'(bus.ERR_CNT), 32'd1);
    gen(3'd1, 4'd0, 8'd4);
    read(8'h00);
    chk("ff2_addr", 32'(bus.FAIL_ADDR), 32'd3);
    chk("ff2_mask", 32'(bus.FAIL_MASK), 32'h01);
    chk("ff2_cnt", 32'(bus.ERR_CNT), 32'd2);
    for (int i = 0; i < 300; i++) read(~m_c);
    chk("cnt_sat", 32'(bus.ERR_CNT), 32'hFF);

    drive(1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 8'd0); cyc();
    drive(1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 1'b1, ~m_c); cyc(); idle();
    chk("start_rd_fail", 32'(bus.FAIL), 32'd0);
    chk("start_rd_cnt", 32'(bus.ERR_CNT), 32'd0);
    gen(3'd6, 4'd1, 8'd7);
    chk("rsv_perr", 32'(bus.PAT_ERR), 32'd1);
    chk("rsv_w", 32'(bus.DATA_MBIST), 32'h00);
    chk("rsv_vld", 32'(bus.DATA_VALID), 32'd1);
    drive(1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 8'd0); cyc(); idle();
    chk("start_perr", 32'(bus.PAT_ERR), 32'd0);

    // START together with a PRBS strobe: seed is emitted, then the sequence continues.
    drive(1'b1, 1'b1, 3'd4, 4'd0, 8'd0, 1'b0, 8'd0); cyc(); idle();
    chk("start_prbs", 32'(bus.DATA_MBIST), 32'h01);
    gen(3'd4, 4'd0, 8'd0);
    chk("start_prbs_next", 32'(bus.DATA_MBIST), 32'hB8);

    for (int i = 0; i < 600; i++) begin
      logic [2:0] p;
      logic [7:0] rd;
      p  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_c;
      drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), p,
            4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)), rd);
      cyc();
    end
    idle();

    // Asynchronous reset in the middle of a cycle clears state without a clock edge.
    gen(3'd0, 4'd1, 8'd5);
    read(8'h12);
    #2 nreset = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 nreset = 1'b1;
    gen(3'd4, 4'd0, 8'd0);
    chk("prbs_after_rst", 32'(bus.DATA_MBIST), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
